// File: rtl/imem_pkg.sv
// imem_pkg: shared types, sizes and signature step for the instruction ROM scrubber.
package imem_pkg;
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_WORD_W = 32;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} scrub_state_t;

    function automatic logic [IMEM_WORD_W-1:0] sig_step(input logic [IMEM_WORD_W-1:0] acc,
                                                        input logic [IMEM_WORD_W-1:0] word);
        return {acc[IMEM_WORD_W-2:0], acc[IMEM_WORD_W-1]} ^ word;
    endfunction
endpackage

// File: rtl/scrub_sig_engine.sv
// scrub_sig_engine: walks the ROM, folds each word into a rotating-XOR signature,
// compares against the golden value and optionally rescans periodically.
module scrub_sig_engine
    import imem_pkg::*;
#(
    parameter int N            = IMEM_WORD_W,
    parameter int ADDR_W       = IMEM_ADDR_W,
    parameter int DEPTH        = IMEM_DEPTH,
    parameter int SCRUB_PERIOD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              slot,
    input  logic [N-1:0]      mem_q,
    input  logic [N-1:0]      expected_sig,
    output logic [ADDR_W-1:0] pointer,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [N-1:0]      sig
);
    scrub_state_t state;
    logic [N-1:0] acc;
    logic [31:0]  timer;
    logic         last;
    logic         go;

    assign busy = state == SCAN;
    assign done = state == DONE;
    assign last = pointer == ADDR_W'(DEPTH - 1);
    // the timer reaching zero in IDLE behaves exactly like an external start
    assign go   = start || (state == IDLE && timer == 32'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pointer <= '0;
            acc     <= '0;
            timer   <= '0;
            sig     <= '0;
            error   <= 1'b0;
        end else if (state != SCAN && go) begin
            state   <= SCAN;
            pointer <= '0;
            acc     <= '0;
            timer   <= '0;
            error   <= 1'b0;
            if (state == DONE) sig <= acc;
        end else if (state == SCAN) begin
            if (slot) begin
                acc     <= sig_step(acc, mem_q);
                pointer <= last ? pointer : pointer + 1'b1;
                if (last) state <= DONE;
            end
        end else if (state == DONE) begin
            state <= IDLE;
            sig   <= acc;
            error <= error | (acc != expected_sig);
            timer <= 32'(SCRUB_PERIOD);
        end else if (timer != '0) begin
            timer <= timer - 1'b1;
        end
    end
endmodule

// File: rtl/imem_scrub_arbiter.sv
// imem_scrub_arbiter: shares the ROM read port between fetch (priority) and the
// scrub engine, with a starvation counter forcing scrub progress.
module imem_scrub_arbiter
    import imem_pkg::*;
#(
    parameter int N            = IMEM_WORD_W,
    parameter int ADDR_W       = IMEM_ADDR_W,
    parameter int DEPTH        = IMEM_DEPTH,
    parameter int STARVE_LIMIT = 8,
    parameter int SCRUB_PERIOD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_grant,
    output logic [N-1:0]      fetch_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_q,
    input  logic              scrub_start,
    input  logic [N-1:0]      expected_sig,
    output logic              scrub_busy,
    output logic              scrub_done,
    output logic              scrub_error,
    output logic [N-1:0]      scrub_sig
);
    logic [ADDR_W-1:0] pointer;
    logic [7:0]        starve;
    logic              scrub_slot;

    assign scrub_slot  = scrub_busy && (!fetch_req || starve == 8'(STARVE_LIMIT));
    assign mem_addr    = scrub_slot ? pointer : fetch_addr;
    assign fetch_grant = fetch_req && !scrub_slot;
    assign fetch_data  = mem_q;

    always_ff @(posedge clk) begin
        if (reset || !scrub_busy || scrub_slot) starve <= '0;
        else if (starve != 8'(STARVE_LIMIT)) starve <= starve + 1'b1;
    end

    scrub_sig_engine #(
        .N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SCRUB_PERIOD(SCRUB_PERIOD)
    ) engine (
        .clk(clk),
        .reset(reset),
        .start(scrub_start),
        .slot(scrub_slot),
        .mem_q(mem_q),
        .expected_sig(expected_sig),
        .pointer(pointer),
        .busy(scrub_busy),
        .done(scrub_done),
        .error(scrub_error),
        .sig(scrub_sig)
    );
endmodule

// File: tb/tb_imem_scrub_arbiter.sv
// tb_imem_scrub_arbiter: directed checks of arbitration, scan signature,
// starvation, reset abort and auto-rescan on a DEPTH=4 configuration.
module tb_imem_scrub_arbiter;
    logic        clk = 1'b0;
    logic        reset, fetch_req, scrub_start;
    logic [9:0]  fetch_addr, mem_addr;
    logic [31:0] fetch_data, mem_q, expected_sig, scrub_sig;
    logic        fetch_grant, scrub_busy, scrub_done, scrub_error;
    logic [31:0] rom [0:1023];
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    assign mem_q = rom[mem_addr];

    imem_scrub_arbiter #(
        .N(32), .ADDR_W(10), .DEPTH(4), .STARVE_LIMIT(3), .SCRUB_PERIOD(5)
    ) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_grant(fetch_grant), .fetch_data(fetch_data), .mem_addr(mem_addr),
        .mem_q(mem_q), .scrub_start(scrub_start), .expected_sig(expected_sig),
        .scrub_busy(scrub_busy), .scrub_done(scrub_done), .scrub_error(scrub_error),
        .scrub_sig(scrub_sig)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // start a scan with no fetch traffic and follow it through DONE
    task automatic run_scan(input logic [31:0] es, input logic [31:0] want_sig, input logic want_err);
        expected_sig = es;
        scrub_start = 1'b1;
        tick;
        scrub_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("scan_busy", scrub_busy, 1);
            check("scan_addr", mem_addr, i);
            if (i == 0) check("err_clear", scrub_error, 0);
            tick;
        end
        check("done", scrub_done, 1);
        check("done_busy", scrub_busy, 0);
        tick;
        check("done_pulse", scrub_done, 0);
        check("sig", scrub_sig, want_sig);
        check("err", scrub_error, want_err);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
        rom[0] = 32'h1;
        rom[5] = 32'h5A5A1234;
        rom[10'h3FF] = 32'hCAFEF00D;
        fetch_req = 1'b0;
        fetch_addr = '0;
        scrub_start = 1'b0;
        expected_sig = 32'h8;
        do_reset;
        check("rst_busy", scrub_busy, 0);
        check("rst_done", scrub_done, 0);
        check("rst_err", scrub_error, 0);
        check("rst_sig", scrub_sig, 0);
        check("rst_grant", fetch_grant, 0);

        // fetch in IDLE, top address passes through in the same cycle
        fetch_req = 1'b1;
        fetch_addr = 10'h3FF;
        #1;
        check("idle_grant", fetch_grant, 1);
        check("idle_addr", mem_addr, 32'h3FF);
        check("idle_data", fetch_data, 32'hCAFEF00D);
        fetch_req = 1'b0;
        #1;
        check("idle_nogrant", fetch_grant, 0);

        // single set bit rotates to bit 3; matching then mismatching golden value
        run_scan(32'h8, 32'h8, 1'b0);
        run_scan(32'h9, 32'h8, 1'b1);
        run_scan(32'h8, 32'h8, 1'b0);

        // mixed contents against the hand-folded signature
        do_reset;
        rom[0] = 32'hDEADBEEF;
        rom[1] = 32'h12345678;
        rom[2] = 32'h0;
        rom[3] = 32'hFFFFFFFF;
        run_scan(32'h42435161, 32'h42435161, 1'b0);

        // fetch held during scan: three grants then one forced scrub slot
        do_reset;
        rom[0] = 32'h1;
        rom[1] = 32'h0;
        rom[2] = 32'h0;
        rom[3] = 32'h0;
        expected_sig = 32'h8;
        fetch_req = 1'b1;
        fetch_addr = 10'd5;
        scrub_start = 1'b1;
        #1;
        check("pre_grant", fetch_grant, 1);
        tick;
        scrub_start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("starve_grant", fetch_grant, (k % 4) != 3);
            if ((k % 4) != 3) begin
                check("starve_data", fetch_data, 32'h5A5A1234);
                check("starve_faddr", mem_addr, 5);
            end else begin
                check("starve_saddr", mem_addr, k / 4);
            end
            tick;
        end
        check("starve_done", scrub_done, 1);
        check("done_grant", fetch_grant, 1);
        tick;
        check("starve_sig", scrub_sig, 32'h8);
        fetch_req = 1'b0;

        // reset in the middle of a scan discards everything
        expected_sig = 32'h9;
        run_scan(32'h9, 32'h8, 1'b1);
        scrub_start = 1'b1;
        tick;
        scrub_start = 1'b0;
        tick;
        tick;
        check("mid_addr", mem_addr, 2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort_busy", scrub_busy, 0);
        check("abort_sig", scrub_sig, 0);
        check("abort_err", scrub_error, 0);
        run_scan(32'h8, 32'h8, 1'b0);

        // auto-rescan after exactly five IDLE cycles; start during SCAN ignored
        for (int i = 0; i < 4; i++) begin
            tick;
            check("period_idle", scrub_busy, 0);
        end
        tick;
        check("auto_busy", scrub_busy, 1);
        check("auto_addr0", mem_addr, 0);
        tick;
        check("auto_addr1", mem_addr, 1);
        scrub_start = 1'b1;
        tick;
        scrub_start = 1'b0;
        check("ign_addr2", mem_addr, 2);
        check("ign_done", scrub_done, 0);
        tick;
        check("ign_addr3", mem_addr, 3);
        tick;
        check("auto_done", scrub_done, 1);
        tick;
        check("auto_done_once", scrub_done, 0);
        check("auto_sig", scrub_sig, 32'h8);
        check("auto_err", scrub_error, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/imem_scrub_arbiter.md
Name: imem_scrub_arbiter

Overview:
- Shares the single combinational read port of the 1024x32 instruction ROM between two requesters: the core's instruction fetch and a background scrub engine.
- The scrub engine walks every ROM word, folds each one into a rotating-XOR signature and compares the result against a golden value. This detects upsets in instruction storage, which matters for the radiation environment.
- Fetch has priority. A starvation counter guarantees scrub progress.
- Sits between the fetch stage (PC address) and the instruction memory.

Parameters:
- N, 32: ROM word width.
- ADDR_W, 10: ROM address width.
- DEPTH, 1024: number of words scanned; must be ≤ 2**ADDR_W.
- STARVE_LIMIT, 8: consecutive denied scrub cycles before scrub is forced a slot; range 1..255.
- SCRUB_PERIOD, 0: cycles from DONE to automatic rescan; 0 disables auto-rescan.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  core requests an instruction read this cycle.
- fetch_addr  in  ADDR_W  word address from the PC.
- fetch_grant  out  1  fetch served this cycle; fetch_data valid this cycle.
- fetch_data  out  N  ROM word for the fetch.
- mem_addr  out  ADDR_W  to the ROM address input.
- mem_q  in  N  ROM read data, combinational from mem_addr.
- scrub_start  in  1  pulse; begins a scan from IDLE or DONE.
- expected_sig  in  N  golden signature, sampled at comparison.
- scrub_busy  out  1  scan in progress.
- scrub_done  out  1  one-cycle pulse at end of scan.
- scrub_error  out  1  sticky mismatch flag.
- scrub_sig  out  N  last completed signature.

Behaviour:
- Reset values:
  - State IDLE; scan pointer 0; accumulator 0; starve counter 0; period timer 0.
  - scrub_busy=0, scrub_done=0, scrub_error=0, scrub_sig=0, fetch_grant=0.
  - Reset mid-scan aborts the scan with the same values. No partial signature is kept.
- States IDLE, SCAN, DONE:
  - IDLE→SCAN on scrub_start. This clears the accumulator, pointer and scrub_error.
  - SCAN→DONE the cycle after the word at DEPTH-1 is accumulated.
  - DONE lasts one cycle. In it, scrub_done=1, scrub_sig=acc, and scrub_error is set if acc != expected_sig. Then DONE→IDLE.
  - scrub_start while in SCAN is ignored. scrub_start while in DONE is honoured as in IDLE.
- Arbitration is combinational within the cycle and there is zero added latency.
  - scrub_slot = (state==SCAN) && (!fetch_req || starve==STARVE_LIMIT).
  - If scrub_slot: mem_addr=pointer, fetch_grant=0. Otherwise mem_addr=fetch_addr and fetch_grant=fetch_req.
  - fetch_data=mem_q at all times. It is meaningful only when fetch_grant=1.
  - When fetch_req=1 and fetch_grant=0, the core must stall and hold fetch_addr.
- Starve counter:
  - Increments when in SCAN and fetch_req blocks scrub.
  - Clears on any scrub slot and outside SCAN.
  - Saturates at STARVE_LIMIT.
- Accumulate on each scrub slot:
  - acc ← {acc[N-2:0],acc[N-1]} ^ mem_q.
  - pointer increments by 1. The pointer never wraps within a scan; it terminates at DEPTH-1.
- Auto-rescan, when SCRUB_PERIOD>0:
  - The timer loads on entering IDLE from DONE and decrements in IDLE.
  - Reaching 0 acts as scrub_start.
  - An external scrub_start in IDLE preempts the timer.
- scrub_sig and scrub_error hold until the next DONE or reset. A new scan start clears scrub_error only.
- A fetch_req with fetch_addr ≥ DEPTH is still passed through unchanged.

Decomposition:
- Shared package imem_pkg:
  - Enum scrub_state_t {IDLE,SCAN,DONE}.
  - Constants IMEM_ADDR_W=10, IMEM_DEPTH=1024, IMEM_WORD_W=32.
  - Function sig_step(acc,word) implementing rotate-left-1 XOR.
- Natural sub-module: scrub_sig_engine (pointer, accumulator, state machine, period timer).
- The top level keeps the arbitration mux and the starve counter.

Test Plan:
1. DEPTH=4, ROM word0=0x00000001 and the rest 0, fetch_req=0, pulse scrub_start → busy for 4 cycles, done pulse on cycle 5, scrub_sig=0x00000008; expected_sig=0x8 gives error=0, expected_sig=0x9 gives error=1.
2. DEPTH=4, ROM={0xDEADBEEF,0x12345678,0,0xFFFFFFFF}, no fetch → scrub_sig equals a model of sig_step; mem_addr sequence 0,1,2,3.
3. STARVE_LIMIT=3, fetch_req held 1 during SCAN → fetch_grant pattern 1,1,1,0 repeating; scrub pointer advances once per 4 cycles; fetch_data during grants equals ROM[fetch_addr].
4. fetch_req=1 with fetch_addr=0x3FF in IDLE → fetch_grant=1 and fetch_data=ROM[0x3FF] in the same cycle.
5. Assert reset at pointer=2 of a DEPTH=4 scan → next cycle: busy=0, sig=0, error=0; a fresh start yields the same result as scenario 1.
6. SCRUB_PERIOD=5, single start → after DONE, IDLE lasts exactly 5 cycles, then busy reasserts without scrub_start. scrub_start during SCAN → no restart and no extra done pulse.
